iterative_alu: RTL

- Execution-side consumer of the 3-bit ALUControl code produced by the ALU decoder.
- Takes operands plus ALUControl through a valid/ready handshake and returns a registered Result and Zero flag through a second valid/ready handshake.
- Logic and arithmetic ops complete in one cycle. Shifts are iterative, one bit position per cycle, so there is no barrel shifter; this serves as the area-lean spare ALU.
- Sits between the register-read/operand-mux stage and writeback/branch-resolve logic.

---
 rtl/iterative_alu.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/iterative_alu.sv
// iterative_alu
//   Area-lean spare ALU. Consumes the 3-bit ALUControl code from the ALU
//   decoder. Logic/arithmetic ops finish in one cycle; shifts walk one bit
//   position per cycle instead of using a barrel shifter.
//
// Ports
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   flush           synchronous abort of any op in flight
//   in_valid/ready  operand handshake (SrcA, SrcB, ALUControl, ShiftArith)
//   ALUControl      000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT,
//                   110 SLL, 111 SRL (ShiftArith=0) / SRA (ShiftArith=1)
//   SrcB[SHAMT_W-1:0] is the shift amount for 110/111
//   out_valid/ready result handshake (Result, Zero)
//   busy            unit is not idle
module iterative_alu #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       ALUControl,
    input  logic             ShiftArith,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [WIDTH-1:0]     work_q;
    logic [SHAMT_W-1:0]   count_q;
    logic                 shift_left_q;
    logic                 shift_arith_q;

    logic                 accept;
    logic                 is_shift;
    logic [SHAMT_W-1:0]   shamt;
    logic                 start_shift;
    logic                 last_shift;
    logic [WIDTH-1:0]     alu_out;
    logic [WIDTH-1:0]     shift_step;

    // in_ready is gated with rst_n so it is low for the whole reset window.
    assign in_ready    = rst_n && (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign busy        = (state_q != IDLE);

    // flush blocks acceptance even though in_ready may be high.
    assign accept      = in_valid && in_ready && !flush;
    assign is_shift    = (ALUControl[2:1] == 2'b11);
    assign shamt       = SrcB[SHAMT_W-1:0];
    assign start_shift = is_shift && (shamt != '0);
    assign last_shift  = (count_q == SHAMT_W'(1));

    // Single-cycle result. Shift codes pass SrcA through, which is exactly
    // the answer for a zero shift amount.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        alu_out = SrcA;
        case (ALUControl)
            3'b000:  alu_out = SrcA + SrcB;
            3'b001:  alu_out = SrcA - SrcB;
            3'b010:  alu_out = SrcA & SrcB;
            3'b011:  alu_out = SrcA | SrcB;
            3'b100:  alu_out = SrcA ^ SrcB;
            3'b101:  alu_out = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
            default: alu_out = SrcA;
        endcase
    end

    // One bit position per cycle; SRA replicates the sign bit.
    always_comb begin
        shift_step = work_q;
        if (shift_left_q) begin
            shift_step = {work_q[WIDTH-2:0], 1'b0};
        end else begin
            shift_step = {shift_arith_q & work_q[WIDTH-1], work_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = start_shift ? SHIFT : DONE;
            SHIFT:   if (last_shift) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // flush outranks accept, shift progress and the output handshake.
        if (flush) begin
            state_d = IDLE;
        end
    end

    // Result/Zero change only when an op completes, so they stay stable
    // through SHIFT, DONE backpressure and after a flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Result        <= '0;
            Zero          <= 1'b0;
            work_q        <= '0;
            count_q       <= '0;
            shift_left_q  <= 1'b0;
            shift_arith_q <= 1'b0;
        end else if (flush) begin
            count_q <= '0;
        end else if (accept) begin
            if (start_shift) begin
                work_q        <= SrcA;
                count_q       <= shamt;
                shift_left_q  <= (ALUControl == 3'b110);
                shift_arith_q <= (ALUControl == 3'b111) && ShiftArith;
            end else begin
                Result <= alu_out;
                Zero   <= (alu_out == '0);
            end
        end else if (state_q == SHIFT) begin
            work_q  <= shift_step;
            count_q <= count_q - SHAMT_W'(1);
            if (last_shift) begin
                Result <= shift_step;
                Zero   <= (shift_step == '0);
            end
        end
    end

endmodule
